// File: rtl/ffe_mac_datapath.sv
// ffe_mac_datapath: time-multiplexed FFE multiply-accumulate datapath.
// Delay line + coef file, one tap product per cycle, rounded/saturated out.
// Ports:
//   ffe_clk, rst (async, active-low)
//   din/shift_en          : sample into delay line (tap[0] newest)
//   rd_en/rd_addr         : accumulate tap[rd_addr]*coef[rd_addr]
//   str_out_n_rst_add_reg : finalize frame, load dout, clear acc
//   coef_wr_en/addr/data  : coefficient write port
//   dout/dout_valid/sat_flag : registered output, valid pulse, clip flag
module ffe_mac_datapath #(
  parameter int DEPTH     = 4,
  parameter int ADDR_SIZE = $clog2(DEPTH),
  parameter int DATA_W    = 8,
  parameter int COEF_W    = 8,
  parameter int OUT_W     = 8,
  parameter int ACC_W     = DATA_W + COEF_W + ADDR_SIZE
) (
  input  logic                 ffe_clk,
  input  logic                 rst,
  input  logic [DATA_W-1:0]    din,
  input  logic                 shift_en,
  input  logic                 rd_en,
  input  logic [ADDR_SIZE-1:0] rd_addr,
  input  logic                 str_out_n_rst_add_reg,
  input  logic                 coef_wr_en,
  input  logic [ADDR_SIZE-1:0] coef_wr_addr,
  input  logic [COEF_W-1:0]    coef_wr_data,
  output logic [OUT_W-1:0]     dout,
  output logic                 dout_valid,
  output logic                 sat_flag
);

  localparam int PROD_W = DATA_W + COEF_W;
  localparam int RND_W  = ACC_W + 1;

  localparam logic signed [RND_W-1:0] HALF =
    RND_W'(2 ** (COEF_W - 2));
  localparam logic signed [RND_W-1:0] SMAX =
    RND_W'(2 ** (OUT_W - 1) - 1);
  localparam logic signed [RND_W-1:0] SMIN =
    RND_W'(-(2 ** (OUT_W - 1)));

  logic signed [DATA_W-1:0] r_tap  [DEPTH];
  logic signed [COEF_W-1:0] r_coef [DEPTH];
  logic signed [ACC_W-1:0]  r_acc;
  logic                     r_primed;
  logic [OUT_W-1:0]         r_dout;
  logic                     r_valid;
  logic                     r_sat;

  logic signed [DATA_W-1:0] w_tap;
  logic signed [COEF_W-1:0] w_coef;
  logic signed [PROD_W-1:0] w_prod;
  logic signed [ACC_W-1:0]  w_prod_x;
  logic signed [ACC_W-1:0]  w_final;
  logic signed [RND_W-1:0]  w_rnd;
  logic [OUT_W-1:0]         w_dout;
  logic                     w_clip;

  // Out-of-range or idle reads select zero operands.
  always_comb begin
    w_tap  = '0;
    w_coef = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (rd_en && rd_addr == ADDR_SIZE'(i)) begin
        w_tap  = r_tap[i];
        w_coef = r_coef[i];
      end
    end
  end

  assign w_prod   = w_tap * w_coef;
  assign w_prod_x = $signed({{(ACC_W - PROD_W){w_prod[PROD_W-1]}},
                             w_prod});
  assign w_final  = r_acc + w_prod_x;

  // Round half up, then drop the Q1.(COEF_W-1) fraction.
  assign w_rnd = ($signed({w_final[ACC_W-1], w_final}) + HALF)
                 >>> (COEF_W - 1);

  always_comb begin
    w_clip = 1'b0;
    w_dout = w_rnd[OUT_W-1:0];
    if (w_rnd > SMAX) begin
      w_clip = 1'b1;
      w_dout = SMAX[OUT_W-1:0];
    end else if (w_rnd < SMIN) begin
      w_clip = 1'b1;
      w_dout = SMIN[OUT_W-1:0];
    end
  end

  always_ff @(posedge ffe_clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_tap[i]  <= '0;
        r_coef[i] <= '0;
      end
      r_primed <= 1'b0;
    end else begin
      if (shift_en) begin
        r_tap[0] <= din;
        for (int k = 1; k < DEPTH; k++)
          r_tap[k] <= r_tap[k-1];
        r_primed <= 1'b1;
      end
      for (int i = 0; i < DEPTH; i++) begin
        if (coef_wr_en && coef_wr_addr == ADDR_SIZE'(i))
          r_coef[i] <= coef_wr_data;
      end
    end
  end

  always_ff @(posedge ffe_clk or negedge rst) begin
    if (!rst) begin
      r_acc   <= '0;
      r_dout  <= '0;
      r_valid <= 1'b0;
      r_sat   <= 1'b0;
    end else begin
      if (str_out_n_rst_add_reg)
        r_acc <= '0;
      else if (rd_en)
        r_acc <= w_final;
      if (str_out_n_rst_add_reg) begin
        r_dout  <= w_dout;
        r_sat   <= w_clip;
        r_valid <= r_primed;
      end else begin
        r_valid <= 1'b0;
      end
    end
  end

  assign dout       = r_dout;
  assign dout_valid = r_valid;
  assign sat_flag   = r_sat;

endmodule

// File: doc/ffe_mac_datapath.md
Name: ffe_mac_datapath

Overview:
- Time-multiplexed multiply-accumulate datapath of the FFE.
- Sits directly downstream of the FFE controller and consumes its shift_en, rd_en, rd_addr and str_out_n_rst_add_reg.
- Holds the sample delay line and the coefficient register file, accumulates one tap product per cycle, and registers a rounded, saturated equalizer output once per frame of DEPTH cycles.

Parameters:
DEPTH, 4, number of taps / cycles per output frame
ADDR_SIZE, $clog2(DEPTH), tap address width
DATA_W, 8, signed input sample width
COEF_W, 8, signed coefficient width, format Q1.(COEF_W-1)
OUT_W, 8, signed output width
ACC_W, DATA_W+COEF_W+ADDR_SIZE, accumulator width

Ports:
ffe_clk  in  1  clock, all state on rising edge
rst  in  1  asynchronous, active-low reset
din  in  DATA_W  signed sample, captured when shift_en=1
shift_en  in  1  from controller: shift din into the delay line
rd_en  in  1  from controller: accumulate tap[rd_addr]*coef[rd_addr]
rd_addr  in  ADDR_SIZE  from controller: tap/coefficient select
str_out_n_rst_add_reg  in  1  from controller: finalize frame, load output, clear accumulator
coef_wr_en  in  1  coefficient write strobe
coef_wr_addr  in  ADDR_SIZE  coefficient write address
coef_wr_data  in  COEF_W  signed coefficient value
dout  out  OUT_W  signed equalized output, registered
dout_valid  out  1  one-cycle pulse, dout updated with a valid frame
sat_flag  out  1  registered alongside dout; 1 if that output was clipped

Behaviour:
- Reset (async, rst=0):
  - taps, coefs, acc, dout, dout_valid, sat_flag and the internal primed flag all go to 0.
  - Reset mid-frame discards the partial sum.
- Product: p = tap[rd_addr] * coef[rd_addr], signed, DATA_W+COEF_W bits, sign-extended to ACC_W.
  - Combinational; uses pre-edge tap and coef values.
- Accumulator, per rising edge, in priority order:
  - rd_en=1 and str=1: final = acc + p; acc <= 0.
  - rd_en=1 and str=0: acc <= acc + p.
  - rd_en=0: acc holds. This covers controller IDLE; a partial frame survives idle and completes on re-entry.
  - str=1 with rd_en=0 never occurs from the controller; if it does, final = acc and acc <= 0.
- Output, on a str edge:
  - r = (final + 2^(COEF_W-2)) >>> (COEF_W-1), i.e. round half up, arithmetic shift.
  - dout <= r saturated to [-2^(OUT_W-1), 2^(OUT_W-1)-1].
  - sat_flag <= 1 if clipped, else 0.
  - dout_valid <= primed.
  - On all other cycles dout_valid <= 0 and dout/sat_flag hold.
- Delay line:
  - On a shift_en edge: tap[k] <= tap[k-1] for k=1..DEPTH-1, and tap[0] <= din.
  - Products in the same cycle use the old taps.
  - primed <= 1 on the first shift_en after reset and stays 1 until reset.
- Frame timing with the controller (rd_addr sequence 0,3,2,1,0,...):
  - The addr-0 cycle asserts shift_en and str together.
  - Output = sum over k of coef[k]*tap[k], with tap[0] the newest sample.
  - A sample shifted at str edge n first appears in dout at str edge n+1, DEPTH cycles later.
  - The first str after reset gives dout_valid=0 because taps are still zero.
- Coefficient file:
  - Written on the coef_wr_en edge.
  - A same-cycle read of the same address returns the old value.
  - Writes are allowed during compute; the new value applies from the next cycle.
- Width: ACC_W guarantees no accumulator overflow for DEPTH terms; clipping happens only at the output stage.
- rd_addr/coef_wr_addr >= DEPTH (non-power-of-2 DEPTH): product treated as 0; write ignored.

Test Plan:
- Reset, coef[0]=64, others 0, controller runs, din=100 constant → first str gives dout_valid=0; next str gives dout=50, dout_valid=1, sat_flag=0.
- All coefs=64, din=40 constant for 3 frames → from the second valid frame on, dout=80 every DEPTH=4 cycles, single-cycle dout_valid pulses.
- Rounding with coef[0]=64 only: din=3 → dout=2; din=-3 → dout=-1; din=1 → dout=1.
- Saturation, all coefs=127: din=127 → dout=127, sat_flag=1; din=-128 → dout=-128, sat_flag=1; then din=0 → dout=0, sat_flag=0.
- Controller load drops at rd_addr=1, held low for 10 cycles, then raised → no dout_valid during idle; the next dout equals the value from an uninterrupted run.
- rst asserted mid-frame with acc nonzero → all outputs 0 immediately; the first str after release gives dout_valid=0; the same-cycle coefficient write/read to address 2 uses the old coefficient.
